// File: rtl/vdp_layer_fetch_sequencer.sv
// Per-line VRAM fetch sequencer: for each enabled layer and column, read a map word,
// then the tile row it points to, and hand the tile row to the pixel pipeline.
module vdp_layer_fetch_sequencer #(
  parameter int COLUMNS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [3:0]  layer_enable,
  input  logic [13:0] map_address,
  input  logic [13:0] tile_address,
  output logic        vram_read_req,
  input  logic        vram_read_grant,
  output logic [13:0] vram_read_address,
  input  logic [15:0] vram_data,
  output logic [1:0]  current_layer,
  output logic [5:0]  column,
  output logic        tile_data_valid,
  output logic [15:0] tile_data,
  output logic        busy,
  output logic        line_done,
  output logic [2:0]  state_dbg
);

  // Read handshake: vram_read_req stays high with a stable vram_read_address until a
  // cycle where vram_read_grant is also high; that edge completes the read and the
  // word appears on vram_data in the following cycle. Grant is ignored while req is low.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MAP_REQ    = 3'd1,
    MAP_DATA   = 3'd2,
    TILE_LATCH = 3'd3,
    TILE_REQ   = 3'd4,
    TILE_DATA  = 3'd5,
    NEXT       = 3'd6
  } state_e;

  localparam logic [5:0] LAST_COL = 6'(COLUMNS - 1);

  state_e      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  layer_q, layer_d;
  logic [5:0]  column_q, column_d;
  logic [13:0] tile_addr_q, tile_addr_d;
  logic [15:0] tile_data_q, tile_data_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  pick;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] pick_layer(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (!res[2] && mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    layer_d     = layer_q;
    column_d    = column_q;
    tile_addr_d = tile_addr_q;
    tile_data_d = tile_data_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    pick        = 3'b000;
    // A new line always wins, including over an in-flight pair or a pending line_done.
    if (line_start) begin
      pick     = pick_layer(layer_enable, 3'd0);
      mask_d   = layer_enable;
      column_d = 6'd0;
      if (pick[2]) begin
        state_d = MAP_REQ;
        layer_d = pick[1:0];
      end else begin
        state_d = IDLE;
        layer_d = 2'd0;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        MAP_REQ:    if (vram_read_grant) state_d = MAP_DATA;
        MAP_DATA:   state_d = TILE_LATCH;
        TILE_LATCH: begin
          tile_addr_d = tile_address;
          state_d     = TILE_REQ;
        end
        TILE_REQ:   if (vram_read_grant) state_d = TILE_DATA;
        TILE_DATA:  begin
          tile_data_d = vram_data;
          valid_d     = 1'b1;
          state_d     = NEXT;
        end
        NEXT: begin
          if (column_q != LAST_COL) begin
            column_d = column_q + 6'd1;
            state_d  = MAP_REQ;
          end else begin
            column_d = 6'd0;
            pick     = pick_layer(mask_q, {1'b0, layer_q} + 3'd1);
            if (pick[2]) begin
              layer_d = pick[1:0];
              state_d = MAP_REQ;
            end else begin
              layer_d = 2'd0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    req_d  = (state_d == MAP_REQ) || (state_d == TILE_REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mask_q      <= 4'd0;
      layer_q     <= 2'd0;
      column_q    <= 6'd0;
      tile_addr_q <= 14'd0;
      tile_data_q <= 16'd0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      layer_q     <= layer_d;
      column_q    <= column_d;
      tile_addr_q <= tile_addr_d;
      tile_data_q <= tile_data_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The map address comes from external logic that follows current_layer/column,
  // so it is forwarded directly rather than registered a cycle late.
  always_comb begin
    case (state_q)
      MAP_REQ:  vram_read_address = map_address;
      TILE_REQ: vram_read_address = tile_addr_q;
      default:  vram_read_address = 14'd0;
    endcase
  end

  assign vram_read_req   = req_q;
  assign current_layer   = layer_q;
  assign column          = column_q;
  assign tile_data_valid = valid_q;
  assign tile_data       = tile_data_q;
  assign busy            = busy_q;
  assign line_done       = done_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_vdp_layer_fetch_sequencer.sv
// Directed bench for vdp_layer_fetch_sequencer with a small VRAM and tile-address-generator model.
module tb_vdp_layer_fetch_sequencer;

  localparam int COLS = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_MAP_REQ = 3'd1, S_TILE_REQ = 3'd4,
                         S_TILE_DATA = 3'd5, S_NEXT = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [3:0]  layer_enable = 4'd0;
  logic [13:0] map_address;
  logic [13:0] tile_address = 14'd0;
  logic        vram_read_req;
  logic        vram_read_grant = 1'b0;
  logic [13:0] vram_read_address;
  logic [15:0] vram_data = 16'd0;
  logic [1:0]  current_layer;
  logic [5:0]  column;
  logic        tile_data_valid;
  logic [15:0] tile_data;
  logic        busy;
  logic        line_done;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int ndone = 0;
  int nreads = 0;
  int n;
  int v0, d0, r0;
  logic [3:0]  layers_seen;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  vdp_layer_fetch_sequencer #(.COLUMNS(COLS)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .layer_enable(layer_enable),
    .map_address(map_address), .tile_address(tile_address), .vram_read_req(vram_read_req),
    .vram_read_grant(vram_read_grant), .vram_read_address(vram_read_address),
    .vram_data(vram_data), .current_layer(current_layer), .column(column),
    .tile_data_valid(tile_data_valid), .tile_data(tile_data), .busy(busy),
    .line_done(line_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Environment: map address follows layer/column; VRAM returns addr+0x1000 one cycle
  // after a granted read; the tile generator derives its address from last cycle's data.
  assign map_address = 14'h0100 + {6'd0, current_layer, column};

  always @(posedge clk) begin
    vram_data    <= (vram_read_req && vram_read_grant) ? ({2'b00, vram_read_address} + 16'h1000) : 16'h0000;
    tile_address <= vram_data[13:0] ^ 14'h2000;
  end

  function automatic logic [13:0] map_of(input int l, input int c);
    return 14'h0100 + 14'(l * 64 + c);
  endfunction

  function automatic logic [13:0] tile_of(input logic [13:0] m);
    logic [15:0] w;
    w = {2'b00, m} + 16'h1000;
    return w[13:0] ^ 14'h2000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_map(input int l, input int c);
    exp_addr_q.push_back({18'd0, map_of(l, c)});
  endtask

  task automatic push_pair(input int l, input int c);
    logic [13:0] t;
    t = tile_of(map_of(l, c));
    push_map(l, c);
    exp_addr_q.push_back({18'd0, t});
    exp_q.push_back({16'd0, {2'b00, t} + 16'h1000});
  endtask

  // Record this cycle's observable events, then advance to 1ns after the next edge.
  task automatic tick();
    logic [31:0] e;
    if (vram_read_req === 1'b1 && vram_read_grant === 1'b1) begin
      nreads++;
      e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
      chk("rd_addr", {18'd0, vram_read_address}, e);
    end
    if (vram_read_req === 1'b1) layers_seen[current_layer] = 1'b1;
    if (tile_data_valid === 1'b1) begin
      nvalid++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      chk("tile_data", {16'd0, tile_data}, e);
    end
    if (line_done === 1'b1) ndone++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] en);
    layer_enable = en;
    line_start   = 1'b1;
    tick();
    line_start   = 1'b0;
  endtask

  task automatic run_line(output int cycles);
    cycles = 0;
    while (line_done !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
    chk("done_seen", {31'd0, line_done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic wait_state(input logic [2:0] st, input logic [1:0] l, input logic [5:0] c);
    int k;
    k = 0;
    while (!(state_dbg === st && current_layer === l && column === c) && k < 400) begin
      tick();
      k++;
    end
    chk("state_reached", {29'd0, state_dbg}, {29'd0, st});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {31'd0, vram_read_req}, 32'd0);
    chk({tag, "_addr"}, {18'd0, vram_read_address}, 32'd0);
    chk({tag, "_layer"}, {30'd0, current_layer}, 32'd0);
    chk({tag, "_col"}, {26'd0, column}, 32'd0);
    chk({tag, "_valid"}, {31'd0, tile_data_valid}, 32'd0);
    chk({tag, "_data"}, {16'd0, tile_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, line_done}, 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk_all_zero("rst");
    chk("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    vram_read_grant = 1'b1;

    // Single layer, immediate grants: 6 cycles per column, done 24 cycles after busy
    v0 = nvalid; d0 = ndone;
    for (int c = 0; c < COLS; c++) push_pair(0, c);
    pulse_start(4'b0001);
    chk("a_busy_rise", {31'd0, busy}, 32'd1);
    chk("a_state", {29'd0, state_dbg}, {29'd0, S_MAP_REQ});
    chk("a_req", {31'd0, vram_read_req}, 32'd1);
    run_line(n);
    chk("a_latency", n, 32'd24);
    chk("a_valids", nvalid - v0, 32'd4);
    chk("a_dones", ndone - d0, 32'd1);
    chk("a_rd_left", exp_addr_q.size(), 32'd0);

    // Layers 1 and 3 only
    layers_seen = 4'd0;
    v0 = nvalid;
    for (int c = 0; c < COLS; c++) push_pair(1, c);
    for (int c = 0; c < COLS; c++) push_pair(3, c);
    pulse_start(4'b1010);
    chk("b_layer_first", {30'd0, current_layer}, 32'd1);
    run_line(n);
    chk("b_latency", n, 32'd48);
    chk("b_layers_seen", {28'd0, layers_seen}, 32'h0000_000A);
    chk("b_valids", nvalid - v0, 32'd8);

    // Grant withheld for 3 cycles in MAP_REQ
    vram_read_grant = 1'b0;
    for (int c = 0; c < COLS; c++) push_pair(0, c);
    pulse_start(4'b0001);
    for (int i = 0; i < 4; i++) begin
      chk("c_req_hold", {31'd0, vram_read_req}, 32'd1);
      chk("c_addr_hold", {18'd0, vram_read_address}, 32'h0000_0100);
      if (i == 3) vram_read_grant = 1'b1;
      tick();
    end
    tick();
    tick();
    chk("c_tile_req", {29'd0, state_dbg}, {29'd0, S_TILE_REQ});
    chk("c_tile_addr", {18'd0, vram_read_address}, 32'h0000_3100);
    run_line(n);
    chk("c_rd_left", exp_addr_q.size(), 32'd0);

    // No layers enabled
    r0 = nreads; d0 = ndone;
    pulse_start(4'b0000);
    chk("d_done", {31'd0, line_done}, 32'd1);
    chk("d_busy", {31'd0, busy}, 32'd0);
    chk("d_req", {31'd0, vram_read_req}, 32'd0);
    tick();
    chk("d_done_clr", {31'd0, line_done}, 32'd0);
    chk("d_busy_clr", {31'd0, busy}, 32'd0);
    chk("d_no_reads", nreads - r0, 32'd0);
    chk("d_dones", ndone - d0, 32'd1);

    // Restart during TILE_REQ of layer 2 column 3
    v0 = nvalid; d0 = ndone;
    for (int c = 0; c < COLS; c++) push_pair(0, c);
    for (int c = 0; c < COLS - 1; c++) push_pair(2, c);
    push_map(2, COLS - 1);
    pulse_start(4'b0101);
    wait_state(S_TILE_REQ, 2'd2, 6'd3);
    vram_read_grant = 1'b0;
    for (int c = 0; c < COLS; c++) push_pair(0, c);
    for (int c = 0; c < COLS; c++) push_pair(2, c);
    pulse_start(4'b0101);
    vram_read_grant = 1'b1;
    chk("e_restart_state", {29'd0, state_dbg}, {29'd0, S_MAP_REQ});
    chk("e_restart_layer", {30'd0, current_layer}, 32'd0);
    chk("e_restart_col", {26'd0, column}, 32'd0);
    chk("e_busy", {31'd0, busy}, 32'd1);
    run_line(n);
    chk("e_valids", nvalid - v0, 32'd15);
    chk("e_dones", ndone - d0, 32'd1);
    chk("e_rd_left", exp_addr_q.size(), 32'd0);

    // Restart coinciding with the final NEXT suppresses line_done
    d0 = ndone;
    for (int c = 0; c < COLS; c++) push_pair(0, c);
    for (int c = 0; c < COLS; c++) push_pair(0, c);
    pulse_start(4'b0001);
    wait_state(S_NEXT, 2'd0, 6'd3);
    pulse_start(4'b0001);
    chk("f_no_done", {31'd0, line_done}, 32'd0);
    chk("f_busy", {31'd0, busy}, 32'd1);
    chk("f_col", {26'd0, column}, 32'd0);
    run_line(n);
    chk("f_latency", n, 32'd24);
    chk("f_dones", ndone - d0, 32'd1);

    // Asynchronous reset during TILE_DATA
    push_pair(0, 0);
    pulse_start(4'b0001);
    wait_state(S_TILE_DATA, 2'd0, 6'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("g");
    exp_addr_q.delete();
    exp_q.delete();
    v0 = nvalid; d0 = ndone; r0 = nreads;
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("g_no_valid", nvalid - v0, 32'd0);
    chk("g_no_done", ndone - d0, 32'd0);
    chk("g_no_reads", nreads - r0, 32'd0);
    chk("g_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vdp_layer_fetch_sequencer.md
VDP_LAYER_FETCH_SEQUENCER -- requirements
Module: vdp_layer_fetch_sequencer

Interface
REQ-001 Parameter COLUMNS, default 8: map/tile fetch pairs per enabled layer per line, range 1..64.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 line_start  input  1  single-cycle pulse; begins the fetch sequence for one line.
REQ-005 layer_enable  input  4  per-layer enable, sampled on line_start.
REQ-006 map_address  input  14  map word address for current_layer/column, computed externally, combinational.
REQ-007 tile_address  input  14  tile row address from the tile address generator; valid exactly 1 cycle after that generator's vram_data input was valid.
REQ-008 vram_read_req  output  1  VRAM read request to the arbiter.
REQ-009 vram_read_grant  input  1  arbiter grant; read data arrives on vram_data the cycle after grant.
REQ-010 vram_read_address  output  14  word address for the current request.
REQ-011 vram_data  input  16  VRAM read data.
REQ-012 current_layer  output  2  layer being fetched; drives external scroll/base muxes.
REQ-013 column  output  6  column within current layer, 0..COLUMNS-1.
REQ-014 tile_data_valid  output  1  single-cycle strobe: tile_data holds a fetched tile row.
REQ-015 tile_data  output  16  registered tile row word.
REQ-016 busy  output  1  high from the cycle after line_start until line_done.
REQ-017 line_done  output  1  single-cycle strobe: line sequence complete.

Function
REQ-018 States: IDLE, MAP_REQ, MAP_DATA, TILE_LATCH, TILE_REQ, TILE_DATA, NEXT.
REQ-019 IDLE + line_start: latch layer_enable, select the lowest-numbered enabled layer, set column 0, go to MAP_REQ.
REQ-020 MAP_REQ: vram_read_req=1 and vram_read_address=map_address; hold until vram_read_grant is sampled high, then go to MAP_DATA.
REQ-021 MAP_DATA (grant cycle + 1): vram_data is the map word; req=0; next state is TILE_LATCH.
REQ-022 TILE_LATCH (grant + 2): capture tile_address into an internal 14-bit register; next state is TILE_REQ.
REQ-023 TILE_REQ: req=1, vram_read_address=captured tile address; hold until grant, then go to TILE_DATA.
REQ-024 TILE_DATA: capture vram_data into tile_data; tile_data_valid=1 in the following cycle (NEXT).
REQ-025 NEXT: if column < COLUMNS-1, increment column and go to MAP_REQ; otherwise set column 0, advance to the next higher enabled layer and go to MAP_REQ; if no enabled layer remains, pulse line_done and go to IDLE.
REQ-026 current_layer and column stay stable from MAP_REQ through NEXT for each fetch pair.
REQ-027 vram_read_req is asserted only in MAP_REQ and TILE_REQ; vram_read_grant is ignored in all other states.
REQ-028 Minimum pair latency with immediate grants: 6 cycles per column.
REQ-029 line_start with layer_enable=0: busy stays 0, no requests, line_done pulses the next cycle.
REQ-030 line_start while busy: abort the current pair, discard pending data without a tile_data_valid, and restart per REQ-019 in the next cycle; no line_done for the aborted line.
REQ-031 line_start coinciding with the NEXT cycle that would pulse line_done: restart wins, and line_done is suppressed.
REQ-032 Column counter wraps only via REQ-025; column never exceeds COLUMNS-1.

Reset
REQ-033 reset_n low, asynchronously: state IDLE, and all outputs 0 (vram_read_req, vram_read_address, current_layer, column, tile_data_valid, tile_data, busy, line_done); the latched layer mask is 0.
REQ-034 Reset takes effect mid-operation without any further strobe; after release the block waits for line_start.

Verification
REQ-035 COLUMNS=2, enable=4'b0001, grant tied high, map_address=0x0100, tile_address=0x2345 -> reads at 0x0100, 0x2345, 0x0100, 0x2345; two tile_data_valid strobes; line_done 12 cycles after busy rises.
REQ-036 enable=4'b1010 -> current_layer is 1 for all columns, then 3; layers 0 and 2 are never requested.
REQ-037 Grant delayed 3 cycles in MAP_REQ -> req and address are held stable for 4 cycles; tile address is captured exactly 2 cycles after grant.
REQ-038 enable=0 -> no req; line_done 1 cycle after line_start; busy remains 0.
REQ-039 line_start reasserted during TILE_REQ of layer 2 column 3 -> no tile_data_valid for that pair; restart at the lowest enabled layer, column 0.
REQ-040 reset_n asserted during TILE_DATA -> all outputs 0 immediately; no strobe after release.
